// File: rtl/muladd_pkg.sv
// Shared constants and FSM encoding for the muladd operand loader.
// Package: SIZE, DATA_W, ADDR_W, RES_W, loader_state_t.
package muladd_pkg;

    localparam int SIZE   = 16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int RES_W  = 32;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_OUT   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/muladd_operand_ram.sv
// Operand RAM: one write port, one registered read port (ap_memory style).
// Ports: clk, rst_n, we/waddr/wdata, re/raddr -> rdata (1-cycle, holds when re=0).
module muladd_operand_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              in_range;

    assign in_range = {1'b0, raddr} < DEPTH_L;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = in_range ? mem[raddr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/muladd_operand_loader.sv
// Operand feeder for the muladd_0 core: loads SIZE (a,b) pairs, starts the
// core, serves its a/b ap_memory reads and returns ap_return on m_* stream.
// Ports: ap_clk/ap_rst_n, s_* operand stream, core_* ap_ctrl_hs + memories,
// m_* result stream, busy, load_err, chk_mismatch.
// Option: MULADD_OPERAND_LOADER_CHECK_EN builds a shadow accumulator.
module muladd_operand_loader #(
    parameter int SIZE   = muladd_pkg::SIZE,
    parameter int DATA_W = muladd_pkg::DATA_W,
    parameter int ADDR_W = muladd_pkg::ADDR_W,
    parameter int RES_W  = muladd_pkg::RES_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    input  logic              s_last,
    output logic              core_start,
    input  logic              core_done,
    input  logic              core_idle,
    input  logic              core_ready,
    input  logic [ADDR_W-1:0] core_a_address0,
    input  logic [ADDR_W-1:0] core_b_address0,
    input  logic              core_a_ce0,
    input  logic              core_b_ce0,
    output logic [DATA_W-1:0] core_a_q0,
    output logic [DATA_W-1:0] core_b_q0,
    input  logic [RES_W-1:0]  core_return,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [RES_W-1:0]  m_data,
    output logic              busy,
    output logic              load_err,
    output logic              chk_mismatch
);

    import muladd_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RES_W-1:0]  m_data_q, m_data_d;
    logic              load_err_q, load_err_d;
    logic              beat, last_beat, capture;
    logic              unused_idle;

    assign unused_idle = core_idle;

    assign beat      = s_valid && (state_q == ST_LOAD);
    assign last_beat = (wr_ptr_q == LAST_IDX);

    // Handshake outputs decode the state register directly, so an
    // asynchronous reset drops core_start/m_valid immediately.
    assign s_ready    = (state_q == ST_LOAD);
    assign core_start = (state_q == ST_START);
    assign m_valid    = (state_q == ST_OUT);
    assign busy       = (state_q != ST_LOAD);
    assign m_data     = m_data_q;
    assign load_err   = load_err_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        load_err_d = load_err_q;
        capture    = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                if (beat) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // Beat count alone ends the vector; s_last is only audited.
                    if (s_last != last_beat) begin
                        load_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        wr_ptr_d = '0;
                        state_d  = ST_START;
                    end
                end
            end
            ST_START: begin
                if (core_ready) begin
                    capture = core_done;
                    state_d = core_done ? ST_OUT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    capture = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        m_data_d = capture ? core_return : m_data_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_LOAD;
            wr_ptr_q   <= '0;
            m_data_q   <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            m_data_q   <= m_data_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef MULADD_OPERAND_LOADER_CHECK_EN
    logic [RES_W-1:0] acc_q, acc_d;
    logic             chk_q, chk_d;

    always_comb begin
        acc_d = acc_q;
        chk_d = chk_q;
        if (beat) begin
            acc_d = acc_q + RES_W'(s_a) * RES_W'(s_b);
        end
        // Cleared on the way back into LOAD for the next vector.
        if ((state_q == ST_OUT) && m_ready) begin
            acc_d = '0;
        end
        if (capture && (core_return != acc_q)) begin
            chk_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q <= '0;
            chk_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            chk_q <= chk_d;
        end
    end

    assign chk_mismatch = chk_q;
`else
    assign chk_mismatch = 1'b0;
`endif

    muladd_operand_ram #(
        .DEPTH (SIZE),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram_a (
        .clk  (ap_clk),
        .rst_n(ap_rst_n),
        .we   (beat),
        .waddr(wr_ptr_q),
        .wdata(s_a),
        .re   (core_a_ce0),
        .raddr(core_a_address0),
        .rdata(core_a_q0)
    );

    muladd_operand_ram #(
        .DEPTH (SIZE),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram_b (
        .clk  (ap_clk),
        .rst_n(ap_rst_n),
        .we   (beat),
        .waddr(wr_ptr_q),
        .wdata(s_b),
        .re   (core_b_ce0),
        .raddr(core_b_address0),
        .rdata(core_b_q0)
    );

endmodule

// File: tb/tb_muladd_operand_loader.sv
// Directed bench for muladd_operand_loader with a behavioural muladd_0 core.
// Covers load, gaps, ready delay, back-pressure, s_last errors, reset.
module tb_muladd_operand_loader;

    localparam int SIZE = 16;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        s_valid, s_ready, s_last;
    logic [15:0] s_a, s_b;
    logic        core_start, core_done, core_idle, core_ready;
    logic [3:0]  core_a_address0, core_b_address0;
    logic        core_a_ce0, core_b_ce0;
    logic [15:0] core_a_q0, core_b_q0;
    logic [31:0] core_return;
    logic        m_valid, m_ready;
    logic [31:0] m_data;
    logic        busy, load_err, chk_mismatch;

    int asserts = 0;
    int fails   = 0;

    int ready_delay = 0;
    bit force_zero  = 0;

    always #5 ap_clk = ~ap_clk;

    muladd_operand_loader dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_a            (s_a),
        .s_b            (s_b),
        .s_last         (s_last),
        .core_start     (core_start),
        .core_done      (core_done),
        .core_idle      (core_idle),
        .core_ready     (core_ready),
        .core_a_address0(core_a_address0),
        .core_b_address0(core_b_address0),
        .core_a_ce0     (core_a_ce0),
        .core_b_ce0     (core_b_ce0),
        .core_a_q0      (core_a_q0),
        .core_b_q0      (core_b_q0),
        .core_return    (core_return),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .busy           (busy),
        .load_err       (load_err),
        .chk_mismatch   (chk_mismatch)
    );

    // Behavioural core: ready after ready_delay cycles, then reads all
    // SIZE elements through the ap_memory ports and reports the sum.
    initial begin : core_model
        int ph, cnt, idx;
        logic [31:0] sum;
        ph = 0; cnt = 0; idx = 0; sum = '0;
        core_ready = 0; core_done = 0; core_idle = 1;
        core_a_ce0 = 0; core_b_ce0 = 0;
        core_a_address0 = '0; core_b_address0 = '0;
        core_return = '0;
        forever begin
            @(negedge ap_clk);
            core_ready = 0;
            core_done  = 0;
            core_a_ce0 = 0;
            core_b_ce0 = 0;
            if (!ap_rst_n) begin
                ph = 0;
                core_idle = 1;
            end else begin
                case (ph)
                    0: if (core_start === 1'b1) begin
                        sum = '0; idx = 0; cnt = ready_delay;
                        core_idle = 0;
                        if (cnt == 0) begin
                            core_ready = 1; ph = 2;
                        end else begin
                            ph = 1;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            core_ready = 1; ph = 2;
                        end
                    end
                    default: begin
                        if (idx > 0)
                            sum += 32'(core_a_q0) * 32'(core_b_q0);
                        if (idx < SIZE) begin
                            core_a_ce0 = 1; core_b_ce0 = 1;
                            core_a_address0 = 4'(idx);
                            core_b_address0 = 4'(idx);
                            idx++;
                        end else begin
                            core_done = 1;
                            core_return = force_zero ? 32'h0 : sum;
                            core_idle = 1;
                            ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Drive one SIZE-beat vector, one beat per cycle (or every other cycle).
    task automatic load_vec(input bit ones, input bit gap, input int last_at);
        for (int i = 0; i < SIZE; i++) begin
            if (gap) begin
                @(negedge ap_clk);
                s_valid = 0;
                s_last  = 0;
            end
            @(negedge ap_clk);
            s_valid = 1;
            s_a     = ones ? 16'hFFFF : 16'(i);
            s_b     = ones ? 16'hFFFF : 16'(i + 1);
            s_last  = (i == last_at);
        end
        @(negedge ap_clk);
        s_valid = 0;
        s_last  = 0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (m_valid !== 1'b1 && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        asserts++;
        if (m_valid !== 1'b1) begin
            fails++;
            $display("FAIL wait_m_valid: m_valid=%b after %0d cycles, required 1",
                     m_valid, n);
        end
    endtask

    task automatic accept_out();
        @(negedge ap_clk);
        m_ready = 1;
        @(negedge ap_clk);
        m_ready = 0;
    endtask

    task automatic test_reset();
        asserts++;
        if ({s_ready, core_start, m_valid, busy, load_err, chk_mismatch}
            !== 6'b100000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 100000",
                     {s_ready, core_start, m_valid, busy, load_err, chk_mismatch});
        end
        asserts++;
        if ({m_data, core_a_q0, core_b_q0} !== 64'h0) begin
            fails++;
            $display("FAIL reset_data: m_data=%h a_q0=%h b_q0=%h required 0",
                     m_data, core_a_q0, core_b_q0);
        end
    endtask

    task automatic test_basic();
        load_vec(0, 0, SIZE - 1);
        asserts++;
        if (core_start !== 1'b1 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_start: core_start=%b s_ready=%b required 1/0",
                     core_start, s_ready);
        end
        wait_valid();
        asserts++;
        if (m_data !== 32'h0000_0550) begin
            fails++;
            $display("FAIL basic_data: m_data=%h required 00000550", m_data);
        end
        asserts++;
        if (load_err !== 1'b0 || chk_mismatch !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_flags: load_err=%b chk=%b busy=%b required 0/0/1",
                     load_err, chk_mismatch, busy);
        end
        accept_out();
    endtask

    task automatic test_gapped();
        int early = 0;
        for (int i = 0; i < SIZE; i++) begin
            @(negedge ap_clk);
            s_valid = 0;
            s_last  = 0;
            if (core_start !== 1'b0) early++;
            @(negedge ap_clk);
            if (core_start !== 1'b0) early++;
            s_valid = 1;
            s_a     = 16'(i);
            s_b     = 16'(i + 1);
            s_last  = (i == SIZE - 1);
        end
        @(negedge ap_clk);
        s_valid = 0;
        s_last  = 0;
        asserts++;
        if (early != 0 || core_start !== 1'b1) begin
            fails++;
            $display("FAIL gapped_start: early=%0d core_start=%b required 0/1",
                     early, core_start);
        end
        wait_valid();
        asserts++;
        if (m_data !== 32'h0000_0550) begin
            fails++;
            $display("FAIL gapped_data: m_data=%h required 00000550", m_data);
        end
        accept_out();
    endtask

    task automatic test_ready_delay();
        int hi = 0;
        ready_delay = 3;
        load_vec(0, 0, SIZE - 1);
        while (core_start === 1'b1 && hi < 20) begin
            hi++;
            @(negedge ap_clk);
        end
        asserts++;
        if (hi != 4) begin
            fails++;
            $display("FAIL ready_delay_start: core_start high %0d cycles, required 4",
                     hi);
        end
        wait_valid();
        asserts++;
        if (m_data !== 32'h0000_0550) begin
            fails++;
            $display("FAIL ready_delay_data: m_data=%h required 00000550", m_data);
        end
        accept_out();
        ready_delay = 0;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        load_vec(0, 0, SIZE - 1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            if (m_valid !== 1'b1 || s_ready !== 1'b0 ||
                m_data !== 32'h0000_0550) bad++;
        end
        asserts++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure_hold: %0d bad cycles, required 0", bad);
        end
        m_ready = 1;
        @(negedge ap_clk);
        m_ready = 0;
        asserts++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_release: s_ready=%b m_valid=%b busy=%b required 1/0/0",
                     s_ready, m_valid, busy);
        end
    endtask

    task automatic test_last_err();
        int early = 0;
        for (int i = 0; i < SIZE; i++) begin
            @(negedge ap_clk);
            if (core_start !== 1'b0) early++;
            s_valid = 1;
            s_a     = 16'hFFFF;
            s_b     = 16'hFFFF;
            s_last  = (i == 7);
        end
        @(negedge ap_clk);
        s_valid = 0;
        s_last  = 0;
        asserts++;
        if (early != 0 || core_start !== 1'b1) begin
            fails++;
            $display("FAIL last_err_len: early=%0d core_start=%b required 0/1",
                     early, core_start);
        end
        asserts++;
        if (load_err !== 1'b1) begin
            fails++;
            $display("FAIL last_err_flag: load_err=%b required 1", load_err);
        end
        wait_valid();
        asserts++;
        if (m_data !== 32'hFFE0_0010) begin
            fails++;
            $display("FAIL last_err_data: m_data=%h required ffe00010", m_data);
        end
        asserts++;
        if (chk_mismatch !== 1'b0) begin
            fails++;
            $display("FAIL last_err_chk: chk_mismatch=%b required 0", chk_mismatch);
        end
        accept_out();
    endtask

    task automatic test_chk();
        logic exp_chk;
`ifdef MULADD_OPERAND_LOADER_CHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        force_zero = 1;
        load_vec(1, 0, SIZE - 1);
        wait_valid();
        asserts++;
        if (m_data !== 32'h0 || chk_mismatch !== exp_chk) begin
            fails++;
            $display("FAIL chk_zero: m_data=%h chk=%b required 00000000/%b",
                     m_data, chk_mismatch, exp_chk);
        end
        accept_out();
        force_zero = 0;
    endtask

    task automatic test_reset_run();
        load_vec(0, 0, SIZE - 1);
        @(negedge ap_clk);
        @(negedge ap_clk);
        #2;
        ap_rst_n = 0;
        #1;
        asserts++;
        if (core_start !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 ||
            load_err !== 1'b0 || chk_mismatch !== 1'b0) begin
            fails++;
            $display("FAIL reset_run_async: start=%b m_valid=%b busy=%b err=%b chk=%b required 0",
                     core_start, m_valid, busy, load_err, chk_mismatch);
        end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1;
        @(negedge ap_clk);
        asserts++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_run_ready: s_ready=%b required 1", s_ready);
        end
        load_vec(0, 0, SIZE - 1);
        wait_valid();
        asserts++;
        if (m_data !== 32'h0000_0550 || load_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_run_data: m_data=%h err=%b required 00000550/0",
                     m_data, load_err);
        end
        accept_out();
    endtask

    initial begin
        ap_rst_n = 0;
        s_valid  = 0;
        s_last   = 0;
        s_a      = '0;
        s_b      = '0;
        m_ready  = 0;
        repeat (3) @(negedge ap_clk);
        test_reset();
        ap_rst_n = 1;
        @(negedge ap_clk);
        test_reset();
        test_basic();
        test_gapped();
        test_ready_delay();
        test_back_to_back();
        test_last_err();
        test_chk();
        test_reset_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
